uart_matmul_nxn: RTL and testbench

UART_MATMUL_NXN -- requirements
Module: uart_matmul_nxn

---
 rtl/uart_matmul_pkg.sv | 26 ++
 rtl/matmul_mac.sv | 42 ++++
 rtl/uart_matmul_nxn.sv | 196 +++++++++++++++++++
 tb/tb_uart_matmul_nxn.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_matmul_pkg.sv
// Shared definitions for the UART-attached NxN matrix multiplier: FSM encoding,
// command-byte bit positions and result-sizing helpers.
package uart_matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT    = 3'd4
  } state_t;

  localparam int CMD_SIGNED_BIT = 0;
  localparam int CMD_FULL_BIT   = 1;
  localparam int CMD_RSVD_LSB   = 2;

  // Accumulator width that can hold a sum of n full-scale products without overflow.
  function automatic int result_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int bytes_per_elem(input int rw);
    return (rw + 7) / 8;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate lane: DW x DW signed/unsigned product added into an
// RW-bit accumulator; 'sum' is the post-accumulate value of the current cycle.
module matmul_mac #(
  parameter int DW = 8,
  parameter int RW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clear,
  input  logic          signed_mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [RW-1:0] sum
);

  logic signed [DW:0]     a_ext;
  logic signed [DW:0]     b_ext;
  logic signed [2*DW+1:0] prod;
  logic        [RW-1:0]   prod_rw;
  logic        [RW-1:0]   acc;

  // One extra bit lets both operand kinds share a single signed multiplier.
  assign a_ext = {signed_mode & a[DW-1], a};
  assign b_ext = {signed_mode & b[DW-1], b};
  assign prod  = a_ext * b_ext;

  // Any product fits in 2*DW+1 signed bits, so the top bit is a pure sign copy.
  assign prod_rw = {{(RW-2*DW-1){prod[2*DW+1]}}, prod[2*DW:0]};
  assign sum     = (clear ? '0 : acc) + prod_rw;

  // NOTE: state is written with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/uart_matmul_nxn.sv
// Byte-stream NxN matrix multiplier: receives a command plus A and B over a UART
// byte interface, computes C = A x B one MAC per cycle, and streams C back.
module uart_matmul_nxn
  import uart_matmul_pkg::*;
#(
  parameter int N           = 2,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       tx_oe,
  output logic [7:0] obs_byte,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int RW  = result_width(N, DW);
  localparam int BPE = bytes_per_elem(RW);
  localparam int NN  = N * N;
  localparam int NAB = 2 * NN;
  localparam int CW  = $clog2(N);
  localparam int AW  = $clog2(NAB);
  localparam int EW  = $clog2(NN);
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  state_t state, state_nxt;

  logic          mode_signed, mode_full;
  logic [7:0]    ab_mem [NAB];  // A at [0..NN-1], B at [NN..2*NN-1]
  logic [RW-1:0] c_mem  [NN];
  logic [AW-1:0] ld_cnt;
  logic [CW-1:0] ci, cj, ck;
  logic [EW-1:0] se;
  logic [BW-1:0] sb;
  logic [TW-1:0] to_cnt;
  logic          wait_first;

  logic          cmd_bad, ld_last, timeout, k_last, j_last, i_last, comp_last;
  logic          byte_last, elem_last, wait_ok;
  logic [AW-1:0] a_idx, b_idx;
  logic [EW-1:0] c_idx;
  logic [RW-1:0] mac_sum, c_sel;
  logic [8*BPE-1:0] c_ext;
  logic [7:0]    cur_byte;

  assign cmd_bad   = |rx_data[7:CMD_RSVD_LSB];
  assign ld_last   = (ld_cnt == AW'(NAB - 1));
  assign timeout   = (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign k_last    = (ck == CW'(N - 1));
  assign j_last    = (cj == CW'(N - 1));
  assign i_last    = (ci == CW'(N - 1));
  assign comp_last = i_last && j_last && k_last;
  assign byte_last = !mode_full || (sb == BW'(BPE - 1));
  assign elem_last = (se == EW'(NN - 1));
  assign wait_ok   = !wait_first && !tx_busy;

  assign a_idx = AW'(ci) * AW'(N) + AW'(ck);
  assign b_idx = AW'(NN) + AW'(ck) * AW'(N) + AW'(cj);
  assign c_idx = EW'(ci) * EW'(N) + EW'(cj);

  matmul_mac #(.DW(DW), .RW(RW)) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == ST_COMPUTE),
    .clear       (ck == '0),
    .signed_mode (mode_signed),
    .a           (ab_mem[a_idx]),
    .b           (ab_mem[b_idx]),
    .sum         (mac_sum)
  );

  // The top byte of a full-precision element carries the sign (or zero) extension.
  assign c_sel    = c_mem[se];
  assign c_ext    = {{(8*BPE-RW){mode_signed & c_sel[RW-1]}}, c_sel};
  assign cur_byte = c_ext[{sb, 3'b000} +: 8];

  assign busy     = (state != ST_IDLE);
  assign tx_oe    = (state == ST_SEND) || (state == ST_WAIT);
  assign tx_start = (state == ST_SEND);
  assign tx_data  = tx_start ? cur_byte : obs_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first guarantees every path drives state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (rx_valid && !cmd_bad) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (rx_valid && ld_last)  state_nxt = ST_COMPUTE;
        else if (!rx_valid && timeout) state_nxt = ST_IDLE;
      end
      ST_COMPUTE: if (comp_last) state_nxt = ST_SEND;
      ST_SEND:    state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (wait_ok) state_nxt = (elem_last && byte_last) ? ST_IDLE : ST_SEND;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: operand and result storage is reset on purpose so an aborted
  // transaction can never leak stale data into a later one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_signed <= 1'b0;
      mode_full   <= 1'b0;
      ld_cnt      <= '0;
      to_cnt      <= '0;
      ci          <= '0;
      cj          <= '0;
      ck          <= '0;
      se          <= '0;
      sb          <= '0;
      wait_first  <= 1'b0;
      obs_byte    <= 8'h00;
      done        <= 1'b0;
      err         <= 1'b0;
      for (int n = 0; n < NAB; n++) ab_mem[n] <= 8'h00;
      for (int n = 0; n < NN; n++)  c_mem[n]  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          ld_cnt <= '0;
          to_cnt <= '0;
          ci     <= '0;
          cj     <= '0;
          ck     <= '0;
          se     <= '0;
          sb     <= '0;
          if (rx_valid) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              mode_signed <= rx_data[CMD_SIGNED_BIT];
              mode_full   <= rx_data[CMD_FULL_BIT];
            end
          end
        end
        ST_LOAD: begin
          // A byte landing on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            ab_mem[ld_cnt] <= rx_data;
            ld_cnt         <= ld_cnt + AW'(1);
            to_cnt         <= '0;
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_COMPUTE: begin
          ck <= k_last ? '0 : ck + CW'(1);
          if (k_last) begin
            c_mem[c_idx] <= mac_sum;
            cj <= j_last ? '0 : cj + CW'(1);
            if (j_last) ci <= i_last ? '0 : ci + CW'(1);
          end
        end
        ST_SEND: begin
          obs_byte   <= cur_byte;
          wait_first <= 1'b1;
        end
        ST_WAIT: begin
          // tx_busy may not have risen yet in the first cycle, so it is ignored there.
          wait_first <= 1'b0;
          if (wait_ok) begin
            if (byte_last) begin
              sb <= '0;
              if (elem_last) done <= 1'b1;
              else           se   <= se + EW'(1);
            end else begin
              sb <= sb + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matmul_nxn.sv
// Scoreboard bench for uart_matmul_nxn: a behavioural matrix model queues the
// expected TX bytes, and an independent monitor checks each tx_start against it.
module tb_uart_matmul_nxn;

  localparam int N       = 2;
  localparam int NN      = N * N;
  localparam int TMO     = 300;
  localparam int RW      = 16 + $clog2(N);
  localparam int NB_FULL = (RW + 7) / 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_oe;
  logic [7:0] obs_byte;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0, err_cnt = 0, tx_count = 0;
  bit busy_seen = 0, oe_seen = 0;
  int busy_min = 0, busy_max = 6;

  logic [7:0] a1[NN] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] b1[NN] = '{8'd5, 8'd6, 8'd7, 8'd8};
  logic [7:0] aff[NN] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] as1[NN] = '{8'hFF, 8'd2, 8'd3, 8'd4};

  uart_matmul_nxn #(.N(N), .DW(8), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_oe    (tx_oe),
    .obs_byte (obs_byte),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: plain integer matrix product, then byte serialisation.
  task automatic push_expected(input logic [7:0] cmd, input logic [7:0] a[NN], input logic [7:0] b[NN]);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int acc, av, bv, nb;
        acc = 0;
        for (int k = 0; k < N; k++) begin
          av = cmd[0] ? int'($signed(a[i*N+k])) : int'(a[i*N+k]);
          bv = cmd[0] ? int'($signed(b[k*N+j])) : int'(b[k*N+j]);
          acc += av * bv;
        end
        nb = cmd[1] ? NB_FULL : 1;
        for (int by = 0; by < nb; by++) exp_q.push_back(8'((acc >>> (8 * by)) & 255));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic load_txn(input logic [7:0] cmd, input logic [7:0] a[NN], input logic [7:0] b[NN]);
    push_expected(cmd, a, b);
    send_byte(cmd);
    for (int x = 0; x < NN; x++) begin gap(); send_byte(a[x]); end
    for (int x = 0; x < NN; x++) begin gap(); send_byte(b[x]); end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] a[NN], input logic [7:0] b[NN],
                         input bit junk, input bit measure);
    int d0, e0, cyc;
    d0 = done_cnt;
    e0 = err_cnt;
    load_txn(cmd, a, b);
    if (measure) begin
      check("busy_after_load", busy, 1);
      cyc = 0;
      while (!tx_start && cyc < 100) begin @(negedge clk); cyc++; end
      check("compute_latency", cyc, N * N * N);
    end
    if (junk) begin
      send_byte(8'($urandom));
      send_byte(8'($urandom));
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin @(negedge clk); cyc++; end
    check("done_pulse", done_cnt - d0, 1);
    check("no_err", err_cnt - e0, 0);
    check("all_bytes_sent", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"},  tx_data,  0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_oe"},    tx_oe,    0);
    check({tag, "_obs_byte"}, obs_byte, 0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_err"},      err,      0);
  endtask

  // Transmitter model: goes busy for a random number of cycles after each send request.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_busy = 1'b1;
        repeat ($urandom_range(busy_min, busy_max)) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops one expected byte per tx_start and tracks pulse/flag activity.
  initial begin
    bit         prev_start = 0;
    bit         pending_obs = 0;
    logic [7:0] last_sent = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy)  busy_seen = 1;
        if (tx_oe) oe_seen   = 1;
        if (done)  done_cnt++;
        if (err)   err_cnt++;
        if (pending_obs) begin
          check("obs_byte", obs_byte, last_sent);
          pending_obs = 0;
        end
        if (tx_start) begin
          tx_count++;
          check("tx_start_single", prev_start, 0);
          check("tx_oe_at_start", tx_oe, 1);
          if (exp_q.size() == 0) begin
            check("tx_queue_nonempty", 0, 1);
          end else begin
            last_sent = exp_q.pop_front();
            check("tx_byte", tx_data, last_sent);
          end
          pending_obs = 1;
        end
        prev_start = tx_start;
      end else begin
        prev_start  = 0;
        pending_obs = 0;
      end
    end
  end

  initial begin
    int t0, e0, d0, cyc;
    logic [7:0] ra[NN];
    logic [7:0] rb[NN];
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed products: unsigned low byte, unsigned full precision, signed low byte.
    run_txn(8'h00, a1, b1, 0, 1);
    run_txn(8'h02, aff, aff, 0, 0);
    run_txn(8'h01, as1, b1, 0, 0);

    // Reserved command bits set: error only, then a normal transaction.
    busy_seen = 0;
    t0 = tx_count;
    e0 = err_cnt;
    send_byte(8'h80);
    repeat (20) @(negedge clk);
    check("badcmd_err", err_cnt - e0, 1);
    check("badcmd_busy", busy_seen, 0);
    check("badcmd_no_tx", tx_count - t0, 0);
    run_txn(8'h00, a1, b1, 0, 0);

    // Inter-byte timeout after five bytes.
    oe_seen = 0;
    t0 = tx_count;
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'h00);
    for (int x = 0; x < 4; x++) send_byte(8'($urandom));
    repeat (TMO - 5) @(negedge clk);
    check("timeout_not_early", err_cnt - e0, 0);
    repeat (100) @(negedge clk);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_idle", busy, 0);
    check("timeout_no_oe", oe_seen, 0);
    check("timeout_no_tx", tx_count - t0, 0);
    check("timeout_no_done", done_cnt - d0, 0);

    // Asynchronous reset while waiting on the transmitter after byte 2.
    busy_min = 12;
    busy_max = 12;
    t0 = tx_count;
    load_txn(8'h00, a1, b1);
    cyc = 0;
    while (tx_count < t0 + 2 && cyc < 500) begin @(negedge clk); cyc++; end
    check("reach_byte2", tx_count - t0, 2);
    @(posedge clk);
    #2;
    check("pre_reset_oe", tx_oe, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    busy_min = 0;
    busy_max = 6;
    repeat (15) @(negedge clk);
    run_txn(8'h03, as1, aff, 0, 0);

    // Randomized transactions with stray bytes dropped during COMPUTE.
    for (int t = 0; t < 15; t++) begin
      for (int x = 0; x < NN; x++) begin
        ra[x] = 8'($urandom);
        rb[x] = 8'($urandom);
      end
      run_txn(8'($urandom_range(0, 3)), ra, rb, 1, (t % 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
